// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg -- shared CPU constants for the multiply/divide unit.
//   mdop_e          : EX-stage MD operation encodings (also used by the controller)
//   DEF_*_CYCLES    : default busy-cycle counts for mult and div operations
//   CNT_W           : width of the busy-cycle counter
//   md_state_e      : md_unit FSM states
//   is_start_op()   : true for encodings that launch a multi-cycle operation
//   is_div_op()     : true for DIV/DIVU
// -----------------------------------------------------------------------------
package md_unit_pkg;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MTHI  = 4'd5,
        MDOP_MTLO  = 4'd6
    } mdop_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// -----------------------------------------------------------------------------
// md_calc -- combinational multiply/divide datapath.
//   op       in  4   operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a        in  32  rs operand (dividend / multiplicand)
//   b        in  32  rt operand (divisor / multiplier)
//   res      out 64  {hi, lo}: product, or {remainder, quotient}
//   div_zero out 1   DIV/DIVU with a zero divisor (result must not commit)
// -----------------------------------------------------------------------------
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] mul_signed_s;
    logic [63:0] mul_unsigned_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] b_mag_safe_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] sq_mag_s;
    logic [31:0] sr_mag_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;

    // Both products as 64-bit multiplies; the low 64 bits of a sign-extended
    // product equal the two's-complement signed product.
    always_comb begin
        mul_signed_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        mul_unsigned_s = {32'd0, a} * {32'd0, b};
    end

    // Division: signed divide is done on magnitudes so 0x80000000 / -1 falls
    // out naturally (quotient magnitude 0x80000000 negates to itself). A zero
    // divisor is replaced by 1 only to keep the dividers defined; the result
    // is discarded via div_zero.
    always_comb begin
        a_mag_s = a[31] ? (32'd0 - a) : a;
        b_mag_s = b[31] ? (32'd0 - b) : b;
        if (b == 32'd0) begin
            b_safe_s     = 32'd1;
            b_mag_safe_s = 32'd1;
        end else begin
            b_safe_s     = b;
            b_mag_safe_s = b_mag_s;
        end
        uq_s     = a / b_safe_s;
        ur_s     = a % b_safe_s;
        sq_mag_s = a_mag_s / b_mag_safe_s;
        sr_mag_s = a_mag_s % b_mag_safe_s;
        sq_s     = (a[31] ^ b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
        sr_s     = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
    end

    // Result select and divide-by-zero flag.
    always_comb begin
        res      = 64'd0;
        div_zero = 1'b0;
        case (op)
            MDOP_MULT:  res = mul_signed_s;
            MDOP_MULTU: res = mul_unsigned_s;
            MDOP_DIV:   res = {sr_s, sq_s};
            MDOP_DIVU:  res = {ur_s, uq_s};
            default:    res = 64'd0;
        endcase
        if (is_div_op(op) && (b == 32'd0)) begin
            div_zero = 1'b1;
        end else begin
            div_zero = 1'b0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with architectural HI/LO.
//   MULT_CYCLES / DIV_CYCLES : busy cycles for mult / div operations
//   clk    in  1   clock, rising edge
//   clr    in  1   asynchronous active-high reset
//   mdopE  in  4   EX-stage MD operation (7-15 behave as NONE)
//   srcAE  in  32  rs operand
//   srcBE  in  32  rt operand
//   busy   out 1   high while an operation is in flight
//   startE out 1   combinational: mdopE is MULT/MULTU/DIV/DIVU
//   hi     out 32  HI register
//   lo     out 32  LO register
// The result is computed from the operands present at the start edge and
// held in a pending register; HI/LO only change on the final busy edge.
// -----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  mdopE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    output logic        busy,
    output logic        startE,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e          state_r;
    md_state_e          state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [63:0]        res_r;
    logic [63:0]        res_s;
    logic               dz_r;
    logic               dz_s;
    logic [31:0]        hi_r;
    logic [31:0]        hi_s;
    logic [31:0]        lo_r;
    logic [31:0]        lo_s;
    logic               busy_r;
    logic [63:0]        calc_res_s;
    logic               calc_dz_s;

    md_calc u_calc (
        .op       (mdopE),
        .a        (srcAE),
        .b        (srcBE),
        .res      (calc_res_s),
        .div_zero (calc_dz_s)
    );

    assign startE = is_start_op(mdopE);
    assign busy   = busy_r;
    assign hi     = hi_r;
    assign lo     = lo_r;

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        res_s   = res_r;
        dz_s    = dz_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (startE) begin
                    state_s = ST_RUN;
                    res_s   = calc_res_s;
                    dz_s    = calc_dz_s;
                    if (is_div_op(mdopE)) begin
                        cnt_s = CNT_W'(DIV_CYCLES);
                    end else begin
                        cnt_s = CNT_W'(MULT_CYCLES);
                    end
                end else if (mdopE == MDOP_MTHI) begin
                    hi_s = srcAE;
                end else if (mdopE == MDOP_MTLO) begin
                    lo_s = srcAE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Operations arriving in RUN are ignored; the hazard unit
                // is responsible for holding them back.
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    if (!dz_r) begin
                        hi_s = res_r[63:32];
                        lo_s = res_r[31:0];
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; busy is registered from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            res_r   <= 64'd0;
            dz_r    <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            res_r   <= res_s;
            dz_r    <= dz_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mdopE  input  4  EX-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-15 treated as NONE.
REQ-006 SHALL have port srcAE  input  32  rs operand from the ID/EX register (RD1E after forwarding).
REQ-007 SHALL have port srcBE  input  32  rt operand from the ID/EX register (RD2E after forwarding).
REQ-008 SHALL have port busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port startE  output  1  combinational, high when mdopE is 1-4.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.

Function
REQ-012 SHALL be a two-state FSM: IDLE, RUN.
REQ-013 SHALL, in IDLE with startE, at the edge: latch the 64-bit result, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 SHALL drive busy high exactly while in RUN: N cycles for an N-cycle op.
REQ-015 SHALL decrement the counter once per RUN cycle; when it reaches 1, the next edge writes HI/LO, clears busy, and returns to IDLE.
REQ-016 SHALL keep hi/lo at their old values until that commit edge; new values are visible the cycle busy falls.
REQ-017 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned: HI=result[63:32], LO=result[31:0].
REQ-018 SHALL compute DIV/DIVU as LO=quotient, HI=remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-019 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-020 SHALL, for divisor 0, still run DIV_CYCLES busy cycles and then leave HI/LO unchanged.
REQ-021 SHALL, for MTHI/MTLO in IDLE, write srcAE to HI/LO at the edge, with busy never asserted.
REQ-022 SHALL ignore any mdopE other than NONE while in RUN; the hazard unit stalls on (startE | busy) and on any MD-type instruction in ID.
REQ-023 SHALL make the no-op decodes 0 and 7-15 change no state.
REQ-024 SHALL base the computed result only on operands sampled at the start edge; later operand changes do not affect it.

Reset
REQ-025 SHALL, on clr high, asynchronously force IDLE, busy=0, counter=0, hi=0, lo=0, pending result=0.
REQ-026 SHALL, on clr mid-RUN, abort the operation with no HI/LO commit after release.
REQ-027 SHALL accept a start on the first edge after clr deasserts.

Structure
REQ-028 SHALL take the mdop encodings (NONE..MTLO) and the default cycle counts from the shared CPU constants package used by the controller.
REQ-029 SHALL contain one sub-module, md_calc: combinational mult/div producing {hi,lo} and a div-by-zero flag; the FSM/counter stays in md_unit.

Verification
REQ-030 SHALL show MULT with A=0xFFFFFFFE (-2), B=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 SHALL show MULTU with A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL show DIV with A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 SHALL show MTHI A=0x12345678 in IDLE -> hi=0x12345678 the next cycle, busy stays 0; MTLO issued during RUN -> ignored.
REQ-034 SHALL show clr asserted in cycle 3 of a DIV -> busy=0, hi=lo=0 immediately, with no later commit.
REQ-035 SHALL show back-to-back MULT then DIV, where the DIV is held until busy falls -> results correct, with a total of 15 busy cycles.
